// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state encodings plus flag bit positions
// shared by alu_seq and its multiplier.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SHL  = 4'h2,
    OP_SHR  = 4'h3,
    OP_CMP  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_NAND = 4'h8,
    OP_NOR  = 4'h9,
    OP_XNOR = 4'hA,
    OP_NOT  = 4'hB,
    OP_NEG  = 4'hC,
    OP_PASS = 4'hD,
    OP_MUL  = 4'hE,
    OP_SRA  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned FLG_W = 4;
  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_V = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier retiring one multiplier bit per
// cycle; the final sum is presented combinationally during the last busy cycle.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_c_o,
  output logic [2*WIDTH-1:0] product_c_o
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
  localparam int unsigned      PW       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    step_c;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Load on start, otherwise add the shifted multiplicand for each set bit.
  always_comb begin : mul_next
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    step_c   = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = PW'(a_i);
      mplier_d = b_i;
      cnt_d    = CNT_INIT;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_c;
      mcand_d  = {mcand_q[PW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : mul_regs
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_c_o    = busy_q && (cnt_q == '0);
  assign product_c_o = step_c;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result and {V,N,C,Z} flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier behind op E.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             trigger,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  import alu_seq_pkg::*;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [FLG_W-1:0] flags_q, flags_d;

  logic [WIDTH:0]   sum_c, diff_c;
  logic [WIDTH-1:0] alu_y_c;
  logic             alu_cy_c, alu_ov_c;
  logic [FLG_W-1:0] alu_flags_c;
  logic             accept_c;

  // Single-cycle datapath, evaluated on the live inputs and captured at accept.
  always_comb begin : alu_datapath
    sum_c    = {1'b0, a} + {1'b0, b};
    diff_c   = {1'b0, a} - {1'b0, b};
    alu_y_c  = '0;
    alu_cy_c = 1'b0;
    alu_ov_c = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        alu_y_c  = sum_c[WIDTH-1:0];
        alu_cy_c = sum_c[WIDTH];
        alu_ov_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y_c  = diff_c[WIDTH-1:0];
        alu_cy_c = diff_c[WIDTH];
        alu_ov_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        alu_y_c  = {a[WIDTH-2:0], 1'b0};
        alu_cy_c = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_y_c  = {1'b0, a[WIDTH-1:1]};
        alu_cy_c = a[0];
      end
      OP_CMP:  alu_y_c = (a == b) ? '0 : ((a > b) ? WIDTH'(1) : ONES);
      OP_AND:  alu_y_c = a & b;
      OP_OR:   alu_y_c = a | b;
      OP_XOR:  alu_y_c = a ^ b;
      OP_NAND: alu_y_c = ~(a & b);
      OP_NOR:  alu_y_c = ~(a | b);
      OP_XNOR: alu_y_c = ~(a ^ b);
      OP_NOT:  alu_y_c = ~a;
      OP_NEG: begin
        alu_y_c  = (~a) + WIDTH'(1);
        alu_ov_c = (a == MIN_VAL);
      end
      OP_PASS: alu_y_c = a;
      OP_MUL:  alu_y_c = '0;
      OP_SRA: begin
        alu_y_c  = {a[WIDTH-1], a[WIDTH-1:1]};
        alu_cy_c = a[0];
      end
      default: alu_y_c = '0;
    endcase
    alu_flags_c        = '0;
    alu_flags_c[FLG_Z] = (alu_y_c == '0);
    alu_flags_c[FLG_N] = alu_y_c[WIDTH-1];
    alu_flags_c[FLG_C] = alu_cy_c;
    alu_flags_c[FLG_V] = alu_ov_c;
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start_c;
  logic               mul_busy;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;
  logic [FLG_W-1:0]   mul_flags_c;

  assign mul_start_c = accept_c && (op == OP_MUL);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i       (trigger),
    .rst_ni      (rst_n),
    .start_i     (mul_start_c),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (mul_busy),
    .done_c_o    (mul_done_c),
    .product_c_o (mul_prod_c)
  );

  // Carry reports a nonzero upper half of the full product.
  always_comb begin : mul_flag_gen
    mul_flags_c        = '0;
    mul_flags_c[FLG_Z] = (mul_prod_c[WIDTH-1:0] == '0);
    mul_flags_c[FLG_N] = mul_prod_c[WIDTH-1];
    mul_flags_c[FLG_C] = |mul_prod_c[2*WIDTH-1:WIDTH];
  end

  assign in_ready = rst_n && !mul_busy && ((state_q != S_DONE) || out_ready);
`else
  assign in_ready = rst_n && ((state_q != S_DONE) || out_ready);
`endif

  assign accept_c = in_valid && in_ready;

  // Next state: accepting in DONE overlaps the result hand-off with a new op.
  always_comb begin : fsm_next
    state_d = state_q;
    y_d     = y_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          state_d = S_DONE;
          y_d     = alu_y_c;
          flags_d = alu_flags_c;
`ifdef ALU_SEQ_MUL_EN
          if (op == OP_MUL) begin
            state_d = S_BUSY;
            y_d     = y_q;
            flags_d = flags_q;
          end
`endif
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        if (mul_done_c) begin
          state_d = S_DONE;
          y_d     = mul_prod_c[WIDTH-1:0];
          flags_d = mul_flags_c;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge trigger or negedge rst_n) begin : fsm_regs
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8 and WIDTH=16 instances),
// honouring ALU_SEQ_MUL_EN when it is defined for the build.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic trigger = 1'b0;
  logic rst_n   = 1'b1;
  always #5 trigger = ~trigger;

  logic        in8_valid = 1'b0, in8_ready, out8_valid, out8_ready = 1'b1;
  logic [3:0]  op8 = 4'h0, flags8;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00, y8;
  logic        in16_valid = 1'b0, in16_ready, out16_valid, out16_ready = 1'b1;
  logic [3:0]  op16 = 4'h0, flags16;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000, y16;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .trigger(trigger), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready),
    .op(op8), .a(a8), .b(b8), .out_valid(out8_valid), .out_ready(out8_ready),
    .y(y8), .flags(flags8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .trigger(trigger), .rst_n(rst_n), .in_valid(in16_valid), .in_ready(in16_ready),
    .op(op16), .a(a16), .b(b16), .out_valid(out16_valid), .out_ready(out16_ready),
    .y(y16), .flags(flags16)
  );

  // Reference: arithmetic on wide integers, masked to w bits. Returns {V,N,C,Z, y[15:0]}.
  function automatic logic [19:0] ref_alu(int unsigned w, logic [3:0] opc,
                                          longint unsigned x, longint unsigned z);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned msb  = 64'd1 << (w - 1);
    longint unsigned r = 0;
    bit c = 1'b0, v = 1'b0;
    x &= mask;
    z &= mask;
    case (opc)
      4'h0: begin r = x + z; c = (r >> w) != 0; r &= mask;
                  v = ((x & msb) == (z & msb)) && ((r & msb) != (x & msb)); end
      4'h1: begin r = (x - z) & mask; c = x < z;
                  v = ((x & msb) != (z & msb)) && ((r & msb) != (x & msb)); end
      4'h2: begin r = (x << 1) & mask; c = (x & msb) != 0; end
      4'h3: begin r = x >> 1; c = (x & 64'd1) != 0; end
      4'h4: r = (x == z) ? 64'd0 : ((x > z) ? 64'd1 : mask);
      4'h5: r = x & z;
      4'h6: r = x | z;
      4'h7: r = x ^ z;
      4'h8: r = ~(x & z) & mask;
      4'h9: r = ~(x | z) & mask;
      4'hA: r = ~(x ^ z) & mask;
      4'hB: r = ~x & mask;
      4'hC: begin r = (mask + 64'd1 - x) & mask; v = (x == msb); end
      4'hD: r = x;
      4'hE: if (MUL_EN) begin r = x * z; c = (r >> w) != 0; r &= mask; end
      default: begin r = (x >> 1) | (x & msb); c = (x & 64'd1) != 0; end
    endcase
    return {v, (r & msb) != 0, c, r == 0, 16'(r)};
  endfunction

  task automatic cyc();
    @(posedge trigger);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({in8_ready, out8_valid, y8, flags8} !== 14'h0) begin
      n_err++;
      $display("FAIL reset8: got rdy=%b vld=%b y=%h f=%b, want all zero", in8_ready, out8_valid, y8, flags8);
    end
    n_cmp++;
    if ({in16_ready, out16_valid, y16, flags16} !== 22'h0) begin
      n_err++;
      $display("FAIL reset16: got rdy=%b vld=%b y=%h f=%b, want all zero", in16_ready, out16_valid, y16, flags16);
    end
    #3 rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({in8_ready, in16_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, want 11", {in8_ready, in16_ready});
    end
    cyc();
  endtask

  task automatic test_directed();
    logic [3:0] ops [5] = '{4'h0, 4'h1, 4'h4, 4'hC, 4'hF};
    logic [7:0] as  [5] = '{8'hFF, 8'h80, 8'h03, 8'h80, 8'h81};
    logic [7:0] bs  [5] = '{8'h01, 8'h01, 8'h05, 8'h00, 8'h00};
    logic [7:0] ey  [5] = '{8'h00, 8'h7F, 8'hFF, 8'h80, 8'hC0};
    logic [3:0] ef  [5] = '{4'b0011, 4'b1000, 4'b0100, 4'b1100, 4'b0110};
    out8_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op8 = ops[i]; a8 = as[i]; b8 = bs[i]; in8_valid = 1'b1;
      cyc();
      n_cmp++;
      if ({out8_valid, y8, flags8} !== {1'b1, ey[i], ef[i]}) begin
        n_err++;
        $display("FAIL directed[%0d] op=%h: got vld=%b y=%h f=%b, want vld=1 y=%h f=%b",
                 i, ops[i], out8_valid, y8, flags8, ey[i], ef[i]);
      end
    end
    in8_valid = 1'b0;
    cyc();
    n_cmp++;
    if (out8_valid !== 1'b0) begin
      n_err++;
      $display("FAIL directed_drain: got vld=%b, want 0", out8_valid);
    end
  endtask

  task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
    out8_ready = 1'b1;
    op8 = 4'hE; a8 = 8'h10; b8 = 8'h20; in8_valid = 1'b1;
    cyc();
    op8 = 4'h0; a8 = 8'h01; b8 = 8'h01;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({in8_ready, out8_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL mul_busy[%0d]: got rdy=%b vld=%b, want 0 0", i, in8_ready, out8_valid);
      end
      cyc();
    end
    n_cmp++;
    if ({out8_valid, y8, flags8} !== {1'b1, 8'h00, 4'b0011}) begin
      n_err++;
      $display("FAIL mul_result: got vld=%b y=%h f=%b, want vld=1 y=00 f=0011", out8_valid, y8, flags8);
    end
    n_cmp++;
    if (in8_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mul_done_ready: got %b, want 1", in8_ready);
    end
    cyc();
    in8_valid = 1'b0;
    n_cmp++;
    if ({out8_valid, y8, flags8} !== {1'b1, 8'h02, 4'b0000}) begin
      n_err++;
      $display("FAIL mul_then_add: got vld=%b y=%h f=%b, want vld=1 y=02 f=0000", out8_valid, y8, flags8);
    end
    cyc();
`else
    out8_ready = 1'b1; out16_ready = 1'b1;
    op8 = 4'hE; a8 = 8'h10; b8 = 8'h20; in8_valid = 1'b1;
    op16 = 4'hE; a16 = 16'h1234; b16 = 16'h5678; in16_valid = 1'b1;
    cyc();
    in8_valid = 1'b0; in16_valid = 1'b0;
    n_cmp++;
    if ({out8_valid, y8, flags8} !== {1'b1, 8'h00, 4'b0001}) begin
      n_err++;
      $display("FAIL op_e8: got vld=%b y=%h f=%b, want vld=1 y=00 f=0001", out8_valid, y8, flags8);
    end
    n_cmp++;
    if ({out16_valid, y16, flags16} !== {1'b1, 16'h0000, 4'b0001}) begin
      n_err++;
      $display("FAIL op_e16: got vld=%b y=%h f=%b, want vld=1 y=0000 f=0001", out16_valid, y16, flags16);
    end
    cyc();
`endif
  endtask

  task automatic test_backpressure();
    out8_ready = 1'b0;
    op8 = 4'h0; a8 = 8'h7F; b8 = 8'h01; in8_valid = 1'b1;
    cyc();
    op8 = 4'h1; a8 = 8'h05; b8 = 8'h07;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out8_valid, in8_ready, y8, flags8} !== {2'b10, 8'h80, 4'b1100}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b y=%h f=%b, want vld=1 rdy=0 y=80 f=1100",
                 i, out8_valid, in8_ready, y8, flags8);
      end
      cyc();
    end
    out8_ready = 1'b1;
    #1;
    n_cmp++;
    if (in8_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b, want 1", in8_ready);
    end
    cyc();
    in8_valid = 1'b0;
    n_cmp++;
    if ({out8_valid, y8, flags8} !== {1'b1, 8'hFE, 4'b0110}) begin
      n_err++;
      $display("FAIL bp_overlap: got vld=%b y=%h f=%b, want vld=1 y=fe f=0110", out8_valid, y8, flags8);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
`ifdef ALU_SEQ_MUL_EN
    out8_ready = 1'b1;
    op8 = 4'hE; a8 = 8'h0F; b8 = 8'h0F;
`else
    out8_ready = 1'b0;
    op8 = 4'h0; a8 = 8'h0F; b8 = 8'h0F;
`endif
    in8_valid = 1'b1;
    cyc();
    in8_valid = 1'b0;
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in8_ready, out8_valid, y8, flags8} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_mid: got rdy=%b vld=%b y=%h f=%b, want all zero", in8_ready, out8_valid, y8, flags8);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    out8_ready = 1'b1;
    #1;
    n_cmp++;
    if ({in8_ready, out8_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_mid_release: got rdy=%b vld=%b, want 1 0", in8_ready, out8_valid);
    end
    op8 = 4'h0; a8 = 8'h02; b8 = 8'h03; in8_valid = 1'b1;
    cyc();
    in8_valid = 1'b0;
    n_cmp++;
    if ({out8_valid, y8, flags8} !== {1'b1, 8'h05, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_mid_add: got vld=%b y=%h f=%b, want vld=1 y=05 f=0000", out8_valid, y8, flags8);
    end
    cyc();
  endtask

  task automatic test_stream();
    logic [19:0] e8, e16;
    out8_ready = 1'b1; out16_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op8 = 4'($urandom_range(0, 15)); a8 = 8'($urandom); b8 = 8'($urandom);
      op16 = 4'($urandom_range(0, 15)); a16 = 16'($urandom); b16 = 16'($urandom);
`ifdef ALU_SEQ_MUL_EN
      if (op8 == 4'hE) op8 = 4'hF;
      if (op16 == 4'hE) op16 = 4'hF;
`endif
      in8_valid = 1'b1; in16_valid = 1'b1;
      e8  = ref_alu(8, op8, 64'(a8), 64'(b8));
      e16 = ref_alu(16, op16, 64'(a16), 64'(b16));
      #1;
      n_cmp++;
      if ({in8_ready, in16_ready} !== 2'b11) begin
        n_err++;
        $display("FAIL stream_ready[%0d]: got %b, want 11", i, {in8_ready, in16_ready});
      end
      cyc();
      n_cmp++;
      if ({out16_valid, y16, flags16} !== {1'b1, e16[15:0], e16[19:16]}) begin
        n_err++;
        $display("FAIL stream16[%0d] op=%h a=%h b=%h: got vld=%b y=%h f=%b, want vld=1 y=%h f=%b",
                 i, op16, a16, b16, out16_valid, y16, flags16, e16[15:0], e16[19:16]);
      end
      n_cmp++;
      if ({out8_valid, y8, flags8} !== {1'b1, e8[7:0], e8[19:16]}) begin
        n_err++;
        $display("FAIL stream8[%0d] op=%h a=%h b=%h: got vld=%b y=%h f=%b, want vld=1 y=%h f=%b",
                 i, op8, a8, b8, out8_valid, y8, flags8, e8[7:0], e8[19:16]);
      end
    end
    in8_valid = 1'b0; in16_valid = 1'b0;
    cyc();
  endtask

  task automatic test_random_handshake();
    logic [11:0] q [$];
    logic [11:0] expv;
    logic [19:0] e;
    logic [12:0] held_val = '0;
    bit          held = 1'b0;
    bit          acc;
    int          budget = 0;
    in8_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!in8_valid && ($urandom_range(0, 2) != 0)) begin
        op8 = 4'($urandom_range(0, 15)); a8 = 8'($urandom); b8 = 8'($urandom);
        in8_valid = 1'b1;
      end
      out8_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        n_cmp++;
        if ({out8_valid, y8, flags8} !== held_val) begin
          n_err++;
          $display("FAIL hs_hold[%0d]: got %h, want %h", i, {out8_valid, y8, flags8}, held_val);
        end
      end
      held     = out8_valid && !out8_ready;
      held_val = {out8_valid, y8, flags8};
      if (out8_valid && out8_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL hs_spurious[%0d]: got result y=%h with none outstanding", i, y8);
        end else begin
          expv = q.pop_front();
          if ({flags8, y8} !== expv) begin
            n_err++;
            $display("FAIL hs_result[%0d]: got y=%h f=%b, want y=%h f=%b", i, y8, flags8, expv[7:0], expv[11:8]);
          end
        end
      end
      acc = in8_valid && in8_ready;
      if (acc) begin
        e = ref_alu(8, op8, 64'(a8), 64'(b8));
        q.push_back({e[19:16], e[7:0]});
      end
      cyc();
      if (acc) in8_valid = 1'b0;
    end
    out8_ready = 1'b1;
    while ((q.size() != 0) && (budget < 40)) begin
      #1;
      if (out8_valid) begin
        n_cmp++;
        expv = q.pop_front();
        if ({flags8, y8} !== expv) begin
          n_err++;
          $display("FAIL hs_drain_result: got y=%h f=%b, want y=%h f=%b", y8, flags8, expv[7:0], expv[11:8]);
        end
      end
      cyc();
      budget++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL hs_drain: got %0d results outstanding, want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_reset_mid();
    test_stream();
    test_random_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within time limit, want completion");
    $fatal(1);
  end

endmodule
